// File: rtl/fbuf_scanout_if.sv
// Framebuffer read port plus video output stream of the scanout engine.
// master = scanout engine, slave = BRAM/encoder side.
interface fbuf_scanout_if #(
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int FBUF_DATA_WIDTH = 8
);
  logic                       fbuf_en_rd;
  logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr;
  logic [FBUF_DATA_WIDTH-1:0] fbuf_data;
  logic                       vid_hsync;
  logic                       vid_vsync;
  logic                       vid_de;
  logic [23:0]                vid_rgb;
  logic                       frame_start;

  modport master (
    output fbuf_en_rd, fbuf_addr,
    input  fbuf_data,
    output vid_hsync, vid_vsync, vid_de, vid_rgb, frame_start
  );

  modport slave (
    input  fbuf_en_rd, fbuf_addr,
    output fbuf_data,
    input  vid_hsync, vid_vsync, vid_de, vid_rgb, frame_start
  );
endinterface

// File: rtl/fbuf_scanout.sv
// Raster scanout: video timing, framebuffer read-ahead, sync realignment and RGB332->RGB888.
// Optional colour-bar generator enabled by `define FBUF_SCANOUT_TEST_PATTERN_EN (adds test_pattern input).
module fbuf_scanout #(
  parameter int FBUF_ADDR_WIDTH   = 19,
  parameter int FBUF_DATA_WIDTH   = 8,
  parameter int FBUF_READ_LATENCY = 1,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scan_en,
`ifdef FBUF_SCANOUT_TEST_PATTERN_EN
  input  logic test_pattern,
`endif
  fbuf_scanout_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W = $clog2(H_TOTAL);
  localparam int V_W = $clog2(V_TOTAL);
  localparam int L   = FBUF_READ_LATENCY;

  typedef struct packed {
`ifdef FBUF_SCANOUT_TEST_PATTERN_EN
    logic       tp;
    logic [2:0] bar;
`endif
    logic hs;
    logic vs;
    logic de;
    logic first;
  } stage_t;

  localparam stage_t IDLE_ST = '{hs: ~SYNC_POL, vs: ~SYNC_POL, default: '0};

  logic                       run_q, run_d;
  logic [H_W-1:0]             h_q, h_d;
  logic [V_W-1:0]             v_q, v_d;
  logic [FBUF_ADDR_WIDTH-1:0] pix_q, pix_d;
  logic                       en_rd_q, en_rd_d;
  logic [FBUF_ADDR_WIDTH-1:0] addr_q;
  stage_t                     st_d;
  stage_t                     pipe_q [0:L];
  logic                       hs_q, vs_q, de_q, fs_q;
  logic [23:0]                rgb_q, rgb_d;
  logic                       act;
  logic [2:0]                 r, g;
  logic [1:0]                 b;

  // run_q marks that the counters hold a real scan position; (0,0) while idle is not a pixel
  always_comb begin
    run_d = scan_en;
    h_d   = '0;
    v_d   = '0;
    pix_d = '0;
    act   = run_q && (h_q < H_W'(H_ACTIVE)) && (v_q < V_W'(V_ACTIVE));
    if (scan_en && run_q) begin
      h_d   = h_q + H_W'(1);
      v_d   = v_q;
      if (h_q == H_W'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == V_W'(V_TOTAL - 1)) ? '0 : v_q + V_W'(1);
      end
      pix_d = act ? pix_q + FBUF_ADDR_WIDTH'(1) : pix_q;
      if (h_d == '0 && v_d == '0) pix_d = '0;
    end

    st_d    = IDLE_ST;
    en_rd_d = act;
    if (run_q) begin
      st_d.de    = act;
      st_d.first = (h_q == '0) && (v_q == '0);
      if (h_q >= H_W'(H_ACTIVE + H_FP) && h_q < H_W'(H_ACTIVE + H_FP + H_SYNC))
        st_d.hs = SYNC_POL;
      if (v_q >= V_W'(V_ACTIVE + V_FP) && v_q < V_W'(V_ACTIVE + V_FP + V_SYNC))
        st_d.vs = SYNC_POL;
    end
`ifdef FBUF_SCANOUT_TEST_PATTERN_EN
    st_d.tp  = test_pattern;
    st_d.bar = '0;
    for (int k = 1; k < 8; k++)
      if (int'(h_q) >= 80 * k) st_d.bar = 3'(k);
    en_rd_d = act && !test_pattern;
`endif
  end

  // BRAM data for the pixel in the last pipe stage is valid now
  always_comb begin
    r     = bus.fbuf_data[7:5];
    g     = bus.fbuf_data[4:2];
    b     = bus.fbuf_data[1:0];
    rgb_d = '0;
    if (pipe_q[L].de) begin
      rgb_d = {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
`ifdef FBUF_SCANOUT_TEST_PATTERN_EN
      if (pipe_q[L].tp)
        rgb_d = {{8{pipe_q[L].bar[2]}}, {8{pipe_q[L].bar[1]}}, {8{pipe_q[L].bar[0]}}};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      pix_q   <= '0;
      en_rd_q <= 1'b0;
      addr_q  <= '0;
      for (int i = 0; i <= L; i++) pipe_q[i] <= IDLE_ST;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      run_q     <= run_d;
      h_q       <= h_d;
      v_q       <= v_d;
      pix_q     <= pix_d;
      en_rd_q   <= en_rd_d;
      addr_q    <= pix_q;
      pipe_q[0] <= st_d;
      for (int i = 1; i <= L; i++) pipe_q[i] <= pipe_q[i-1];
      hs_q      <= pipe_q[L].hs;
      vs_q      <= pipe_q[L].vs;
      de_q      <= pipe_q[L].de;
      fs_q      <= pipe_q[L].first;
      rgb_q     <= rgb_d;
    end
  end

  assign bus.fbuf_en_rd  = en_rd_q;
  assign bus.fbuf_addr   = addr_q;
  assign bus.vid_hsync   = hs_q;
  assign bus.vid_vsync   = vs_q;
  assign bus.vid_de      = de_q;
  assign bus.vid_rgb     = rgb_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_fbuf_scanout.sv
// Scanout bench: reduced raster geometry, BRAM model with data = addr[7:0]^key, randomized enable gaps.
// A queue-free position model predicts every read-side and video-side output each cycle.
module tb_fbuf_scanout;
  localparam int L  = 2;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scan_en = 1'b0;
  logic       tp = 1'b0;
  logic [7:0] key = 8'h00;
  logic [7:0] br1, br2;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_fs = -1;

  always #5 clk = ~clk;

  fbuf_scanout_if #(.FBUF_ADDR_WIDTH(19), .FBUF_DATA_WIDTH(8)) bus ();

  fbuf_scanout #(
    .FBUF_ADDR_WIDTH(19), .FBUF_DATA_WIDTH(8), .FBUF_READ_LATENCY(L),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scan_en(scan_en),
`ifdef FBUF_SCANOUT_TEST_PATTERN_EN
    .test_pattern(tp),
`endif
    .bus(bus.master)
  );

  // BRAM with two cycles of read latency
  always @(posedge clk) begin
    br1 <= bus.fbuf_en_rd ? (bus.fbuf_addr[7:0] ^ key) : 8'hxx;
    br2 <= br1;
  end
  assign bus.fbuf_data = br2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Bit replication of an n-bit channel equals rounding c*255/(2^n-1)
  function automatic logic [23:0] expand(input logic [7:0] p);
    int rr, gg, bb;
    rr = int'(p[7:5]);
    gg = int'(p[4:2]);
    bb = int'(p[1:0]);
    return {8'((rr * 255 + 3) / 7), 8'((gg * 255 + 3) / 7), 8'(bb * 85)};
  endfunction

  // pos: raster position (linear, 0..FRAME-1) the engine is on, -1 when idle
  int pos = -1;
  int hist [0:L];
  int rd, ob, x, y, ox, oy;
  logic e_de, e_hs, e_vs;
  logic [7:0] d;

  initial for (int i = 0; i <= L; i++) hist[i] = -1;

  always @(posedge clk) begin
    if (!rst_n) begin
      rd = -1; ob = -1; pos = -1;
      for (int i = 0; i <= L; i++) hist[i] = -1;
    end else begin
      rd = pos;
      ob = hist[L];
      for (int i = L; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = rd;
      if (!scan_en) pos = -1;
      else if (pos < 0) pos = 0;
      else pos = (pos + 1) % FRAME;
    end
    cyc++;
    #1;
    x = rd % HT; y = rd / HT;
    if (rd < 0) begin
      check("en_rd_idle", 32'(bus.fbuf_en_rd), 32'd0);
      check("addr_idle", 32'(bus.fbuf_addr), 32'd0);
    end else begin
      check("en_rd", 32'(bus.fbuf_en_rd), 32'(x < HA && y < VA));
      if (x < HA && y < VA) check("addr", 32'(bus.fbuf_addr), 32'(y * HA + x));
    end
    ox = ob % HT; oy = ob / HT;
    e_de = (ob >= 0) && ox < HA && oy < VA;
    e_hs = !((ob >= 0) && ox >= HA + HF && ox < HA + HF + HS);
    e_vs = !((ob >= 0) && oy >= VA + VF && oy < VA + VF + VS);
    d = 8'(oy * HA + ox) ^ key;
    check("de", 32'(bus.vid_de), 32'(e_de));
    check("hsync", 32'(bus.vid_hsync), 32'(e_hs));
    check("vsync", 32'(bus.vid_vsync), 32'(e_vs));
    check("frame_start", 32'(bus.frame_start), 32'(ob == 0));
    check("rgb", 32'(bus.vid_rgb), e_de ? 32'(expand(d)) : 32'd0);
    if (e_de && key == 8'h00) begin
      case (d)
        8'hE0: check("rgb_red", 32'(bus.vid_rgb), 32'h00FF0000);
        8'h1C: check("rgb_green", 32'(bus.vid_rgb), 32'h0000FF00);
        8'h03: check("rgb_blue", 32'(bus.vid_rgb), 32'h000000FF);
        default: ;
      endcase
    end
    if (!rst_n || !scan_en) last_fs = -1;
    else if (bus.frame_start === 1'b1) begin
      if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'(FRAME));
      last_fs = cyc;
    end
  end

  initial begin
    rst_n = 1'b0; scan_en = 1'b0; key = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    scan_en = 1'b1;
    repeat (2 * FRAME + 200) @(negedge clk);
    for (int it = 0; it < 5; it++) begin
      scan_en = 1'b0;
      repeat (6) @(negedge clk);
      key = 8'($urandom);
      repeat ($urandom_range(0, 6)) @(negedge clk);
      scan_en = 1'b1;
      repeat ($urandom_range(50, FRAME + FRAME / 2)) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME + 100) @(negedge clk);
    scan_en = 1'b0;
    @(negedge clk);
    scan_en = 1'b1;
    repeat (300) @(negedge clk);
    scan_en = 1'b0;
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
